// File: rtl/decode_dispatch_queue.sv
// -----------------------------------------------------------------------------
// decode_dispatch_queue
//
// Purpose:
//   In-order buffer between the decode stage and the execution units. It holds
//   decoded instruction records and presents the oldest one to the functional
//   unit named in that record. The head issues only when that unit reports
//   ready. Younger records never bypass a blocked head.
//   stall_o asserts one entry before the queue is full. The decoder has a
//   registered output, so one more record can still arrive after stall_o
//   rises; the spare entry absorbs that record.
//
// Ports:
//   clock_i               single clock, rising edge
//   reset_i               synchronous, active-low reset
//   enable_i              incoming record valid
//   reg1_i/reg2_i/reg3_i  register specifiers      (regWidth each)
//   imm_i                 immediate                (immWidth)
//   bit1_i/bit2_i         flag bits
//   functionalUnitCode_i  target unit code         (2)
//   flush_i               discard all buffered records
//   unitReady_i           per-unit accept, indexed by unit code (4)
//   stall_o               decode must not present a record next cycle
//   reg1_o..functionalUnitCode_o  head-entry fields (don't-care when empty)
//   enable_o              head entry valid
//   overflow_o            sticky: a record arrived while full with no pop
// -----------------------------------------------------------------------------
module decode_dispatch_queue #(
   parameter int         regWidth       = 5,
   parameter int         immWidth       = 6,
   parameter int         depth          = 4,
   parameter logic [1:0] FXUnitCode     = 2'd0,
   parameter logic [1:0] FPUnitCode     = 2'd1,
   parameter logic [1:0] LdStUnitCode   = 2'd2,
   parameter logic [1:0] BranchUnitCode = 2'd3
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                enable_i,
   input  logic [regWidth-1:0] reg1_i,
   input  logic [regWidth-1:0] reg2_i,
   input  logic [regWidth-1:0] reg3_i,
   input  logic [immWidth-1:0] imm_i,
   input  logic                bit1_i,
   input  logic                bit2_i,
   input  logic [1:0]          functionalUnitCode_i,
   input  logic                flush_i,
   input  logic [3:0]          unitReady_i,
   output logic                stall_o,
   output logic [regWidth-1:0] reg1_o,
   output logic [regWidth-1:0] reg2_o,
   output logic [regWidth-1:0] reg3_o,
   output logic [immWidth-1:0] imm_o,
   output logic                bit1_o,
   output logic                bit2_o,
   output logic [1:0]          functionalUnitCode_o,
   output logic                enable_o,
   output logic                overflow_o
);

   localparam int PtrW = $clog2(depth);
   localparam int RecW = 3 * regWidth + immWidth + 2 + 2;
   localparam logic [PtrW:0]   DepthC  = (PtrW + 1)'(depth);
   localparam logic [PtrW:0]   StallC  = (PtrW + 1)'(depth - 1);
   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
   localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);

   // Only ready bits belonging to a defined unit code can release the head.
   localparam logic [3:0] UnitMask = (4'b0001 << FXUnitCode)   |
                                     (4'b0001 << FPUnitCode)   |
                                     (4'b0001 << LdStUnitCode) |
                                     (4'b0001 << BranchUnitCode);

   // Record layout: {reg1, reg2, reg3, imm, bit1, bit2, code}
   logic [RecW-1:0] mem_q [depth];
   logic [RecW-1:0] wr_rec;
   logic [RecW-1:0] head_rec;

   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [PtrW:0]   count_q, count_d;
   logic            overflow_q, overflow_d;

   logic            full;
   logic            pop;
   logic            push;
   logic            wr_en;
   logic [3:0]      ready_masked;

   assign wr_rec = {reg1_i, reg2_i, reg3_i, imm_i, bit1_i, bit2_i, functionalUnitCode_i};

   // Head fields are read combinationally so a record is visible right after
   // the edge that wrote it.
   assign head_rec = mem_q[head_q];
   assign {reg1_o, reg2_o, reg3_o, imm_o, bit1_o, bit2_o, functionalUnitCode_o} = head_rec;

   assign enable_o     = (count_q != '0);
   assign stall_o      = (count_q >= StallC);
   assign overflow_o   = overflow_q;

   assign full         = (count_q == DepthC);
   assign ready_masked = unitReady_i & UnitMask;
   assign pop          = enable_o && ready_masked[functionalUnitCode_o];
   // A full queue still accepts a record when the head leaves in the same cycle.
   assign push         = enable_i && (!full || pop);
   assign wr_en        = push && !flush_i;

   // Next-state for pointers, count and the sticky overflow flag.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + PtrOne;
         if (pop)  head_d = head_q + PtrOne;
         case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
         endcase
         if (enable_i && full && !pop) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage entries have no reset; validity is tracked by count alone.
   generate
      for (genvar gi = 0; gi < depth; gi++) begin : g_entry
         always_ff @(posedge clock_i) begin
            if (reset_i && wr_en && (tail_q == PtrW'(gi))) begin
               mem_q[gi] <= wr_rec;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// -----------------------------------------------------------------------------
// Bench for decode_dispatch_queue. The reference model is a plain queue of
// records plus an overflow flag. The stimulus side drives the inputs and
// pushes accepted records into the model after each edge. The monitor runs
// once per cycle. It checks enable_o, stall_o and overflow_o. Whenever the
// head can issue, it pops the expected record and compares the head fields.
// -----------------------------------------------------------------------------
module tb_decode_dispatch_queue;

   typedef struct packed {
      logic [4:0] reg1;
      logic [4:0] reg2;
      logic [4:0] reg3;
      logic [5:0] imm;
      logic       b1;
      logic       b2;
      logic [1:0] code;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [4:0] reg1_i, reg2_i, reg3_i;
   logic [5:0] imm_i;
   logic       bit1_i, bit2_i;
   logic [1:0] code_i;
   logic       flush;
   logic [3:0] ready;
   logic       stall_o;
   logic [4:0] reg1_o, reg2_o, reg3_o;
   logic [5:0] imm_o;
   logic       bit1_o, bit2_o;
   logic [1:0] code_o;
   logic       enable_o;
   logic       overflow_o;

   rec_t exp_q[$];
   bit   exp_ovf = 1'b0;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   decode_dispatch_queue dut (
      .clock_i              (clk),
      .reset_i              (rst_n),
      .enable_i             (en),
      .reg1_i               (reg1_i),
      .reg2_i               (reg2_i),
      .reg3_i               (reg3_i),
      .imm_i                (imm_i),
      .bit1_i               (bit1_i),
      .bit2_i               (bit2_i),
      .functionalUnitCode_i (code_i),
      .flush_i              (flush),
      .unitReady_i          (ready),
      .stall_o              (stall_o),
      .reg1_o               (reg1_o),
      .reg2_o               (reg2_o),
      .reg3_o               (reg3_o),
      .imm_o                (imm_o),
      .bit1_o               (bit1_o),
      .bit2_o               (bit2_o),
      .functionalUnitCode_o (code_o),
      .enable_o             (enable_o),
      .overflow_o           (overflow_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
   endtask

   // Monitor: samples mid-low-phase, after inputs were driven at the negedge.
   initial begin
      rec_t e;
      rec_t got;
      forever begin
         @(negedge clk);
         #3;
         check("enable_o",   {31'b0, enable_o},   {31'b0, exp_q.size() != 0});
         check("stall_o",    {31'b0, stall_o},    {31'b0, exp_q.size() >= 3});
         check("overflow_o", {31'b0, overflow_o}, {31'b0, exp_ovf});
         if (rst_n && !flush && exp_q.size() != 0 && ready[exp_q[0].code]) begin
            e   = exp_q.pop_front();
            got = '{reg1_o, reg2_o, reg3_o, imm_o, bit1_o, bit2_o, code_o};
            check("head_record", {7'b0, got}, {7'b0, e});
            $display("issue: reg1=%0d reg2=%0d reg3=%0d imm=%0d code=%0d", got.reg1, got.reg2, got.reg3, got.imm, got.code);
         end
      end
   end

   // One cycle of stimulus. The model is updated just after the edge. The
   // monitor has already removed any record that issued at that edge.
   task automatic cycle(input bit c_rst_n, input bit c_en, input rec_t r, input bit c_flush, input logic [3:0] c_ready);
      @(negedge clk);
      rst_n  = c_rst_n;
      en     = c_en;
      {reg1_i, reg2_i, reg3_i, imm_i, bit1_i, bit2_i, code_i} = r;
      flush  = c_flush;
      ready  = c_ready;
      @(posedge clk);
      #1;
      if (!c_rst_n) begin
         exp_q.delete();
         exp_ovf = 1'b0;
      end else if (c_flush) begin
         exp_q.delete();
      end else if (c_en) begin
         if (exp_q.size() < 4) exp_q.push_back(r);
         else exp_ovf = 1'b1;
      end
   endtask

   function automatic rec_t mk(input int r1, input int imm, input int code);
      rec_t r;
      r.reg1 = 5'(r1);
      r.reg2 = 5'(r1 + 7);
      r.reg3 = 5'(r1 + 13);
      r.imm  = 6'(imm);
      r.b1   = imm[0];
      r.b2   = imm[1];
      r.code = 2'(code);
      return r;
   endfunction

   function automatic rec_t rnd();
      rec_t r;
      r = rec_t'($urandom);
      return r;
   endfunction

   initial begin
      rst_n = 1'b0; en = 1'b1; flush = 1'b0; ready = 4'b0000;
      {reg1_i, reg2_i, reg3_i, imm_i, bit1_i, bit2_i, code_i} = '0;

      // Reset held with enable high, then the first push.
      cycle(0, 1, mk(9, 9, 0), 0, 4'b0000);
      cycle(0, 1, mk(9, 9, 0), 0, 4'b0000);
      cycle(1, 1, mk(3, 1, 0), 0, 4'b0000);
      cycle(1, 0, mk(0, 0, 0), 0, 4'b0001);   // pops reg1=3
      cycle(1, 0, mk(0, 0, 0), 0, 4'b0000);

      // Fill to 4 with no unit ready, then a 5th push overflows.
      for (int i = 0; i < 5; i++) cycle(1, 1, mk(i + 1, i + 1, i % 4), 0, 4'b0000);
      cycle(1, 0, mk(0, 0, 0), 0, 4'b0000);

      // Full queue, all ready, push every cycle: one out and one in per cycle.
      for (int i = 0; i < 6; i++) cycle(1, 1, mk(20 + i, 20 + i, i % 4), 0, 4'b1111);
      for (int i = 0; i < 5; i++) cycle(1, 0, mk(0, 0, 0), 0, 4'b1111);

      // Head-of-line blocking on the LdSt unit.
      cycle(0, 0, mk(0, 0, 0), 0, 4'b0000);
      cycle(1, 1, mk(4, 30, 2), 0, 4'b0000);
      cycle(1, 1, mk(5, 31, 0), 0, 4'b0000);
      for (int i = 0; i < 3; i++) cycle(1, 0, mk(0, 0, 0), 0, 4'b1011);
      cycle(1, 0, mk(0, 0, 0), 0, 4'b0100);
      cycle(1, 0, mk(0, 0, 0), 0, 4'b0000);
      cycle(1, 0, mk(0, 0, 0), 0, 4'b0001);

      // Fill 3, then flush together with a push and a poppable head.
      for (int i = 0; i < 3; i++) cycle(1, 1, mk(10 + i, 40 + i, 1), 0, 4'b0000);
      cycle(1, 1, mk(15, 50, 1), 1, 4'b1111);
      cycle(1, 0, mk(0, 0, 0), 0, 4'b1111);

      // Wrap-around: 10 push/pop pairs with imm 1..10.
      for (int i = 1; i <= 10; i++) cycle(1, 1, mk(i, i, i % 4), 0, 4'b1111);
      cycle(1, 0, mk(0, 0, 0), 0, 4'b1111);
      cycle(1, 0, mk(0, 0, 0), 0, 4'b1111);

      // Randomized traffic with occasional flush and reset. Enable sometimes
      // ignores stall so that the overflow path is exercised.
      for (int i = 0; i < 600; i++) begin
         bit r_rst, r_en, r_fl;
         r_rst = ($urandom_range(0, 99) != 0);
         r_fl  = ($urandom_range(0, 39) == 0);
         r_en  = stall_o ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cycle(r_rst, r_en, rnd(), r_fl, 4'($urandom));
      end

      cycle(1, 0, mk(0, 0, 0), 0, 4'b1111);
      @(negedge clk);
      #4;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
